seq_det_stream_ctrl: RTL and testbench
======================================

Name: seq_det_stream_ctrl

Overview:
Controller that feeds parallel words into a programmable Moore serial pattern detector, one bit per clock.
- Accepts words over a valid/ready handshake and serializes them MSB-first.
- Owns and loads the detector pattern; counts detections; raises a sticky threshold interrupt.
- Sits between a word-wide producer and the bit-serial detection datapath; it is the sequencer for the 1001-style Moore detectors.

Parameters:
WORD_W, 8, input word width (>=2)
PAT_W, 4, pattern length in bits (2..WORD_W)
CNT_W, 8, match counter and threshold width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cfg_load  input  1  load cfg_pattern and clear detector history; accepted only in IDLE
cfg_pattern  input  PAT_W  pattern; bit PAT_W-1 is the first bit in time
cfg_thresh  input  CNT_W  irq threshold; 0 disables irq
in_valid  input  1  word offered
in_data  input  WORD_W  word to serialize
in_ready  output  1  word accepted when in_valid & in_ready
irq_clr  input  1  clears irq and match_cnt
ser_bit  output  1  bit currently driven into detector (debug)
busy  output  1  state != IDLE
det  output  1  Moore detector output, high one cycle per match
match_cnt  output  CNT_W  saturating detection count
irq  output  1  sticky threshold interrupt

Behaviour:
- Reset (reset=0, async): state=IDLE, shift reg=0, bit_cnt=0, pattern=1001 zero-extended on the left (for PAT_W=4, 4'b1001), history=0, fill=0, det=0, match_cnt=0, irq=0, ser_bit=0. in_ready=1 after reset release.
- FSM states: IDLE, SHIFT.
  - IDLE: in_ready=1. On accept at cycle T: latch in_data, bit_cnt=0, go to SHIFT.
  - SHIFT: ser_bit = shreg[WORD_W-1-bit_cnt]. Bit k is driven in cycle T+1+k. bit_cnt increments each cycle.
  - At bit_cnt==WORD_W-1, in_ready=1. If a word is accepted then, the next cycle is SHIFT bit 0 of the new word (no bubble); otherwise go to IDLE.
- Detector (Moore):
  - Each SHIFT cycle: history <= {history[PAT_W-2:0], ser_bit}; fill increments, saturating at PAT_W.
  - det is registered: det=1 in the cycle after the completing bit when fill==PAT_W and history==pattern.
  - Overlapping matches count. History persists across words and across IDLE gaps; IDLE cycles shift nothing.
- cfg_load: ignored unless state==IDLE. When accepted: pattern<=cfg_pattern, history=0, fill=0, det=0. If cfg_load and an in_valid accept occur in the same IDLE cycle, the load applies first and the new word uses the new pattern.
- match_cnt: increments on each det=1 cycle, saturating at 2^CNT_W-1.
- irq:
  - Sets when match_cnt transitions to cfg_thresh, with cfg_thresh!=0. Stays set until irq_clr.
  - irq_clr clears irq and match_cnt. If det=1 in the same cycle as irq_clr, match_cnt=1 and irq re-evaluates against 1.
- Reset mid-word aborts the word with no completion signalling.

Optional Feature:
SEQ_DET_LSB_FIRST_EN
- Defined: serialize LSB-first, ser_bit = shreg[bit_cnt]; all other timing identical.
- Undefined: MSB-first as specified above.

Decomposition:
- Package seq_det_pkg holds the state enum (IDLE, SHIFT) and the default pattern constant.
- Sub-module seq_pat_det holds the history register, fill counter and registered det. The controller keeps the FSM, counters and irq.

Test Plan:
- Reset, then pattern 1001; send 8'b10010010 at T -> det=1 at T+5 and T+8; match_cnt=2; in_ready=0 during T+1..T+7.
- Back-to-back: 8'b00000010 then 8'b01000000 with in_valid held -> second word accepted in T+8; bits 1,0,0,1 span the boundary -> det=1 at T+11; busy stays high through T+16.
- cfg_load during SHIFT -> ignored. cfg_load=1 with cfg_pattern=4'b1111 in IDLE, then send 8'hFF -> det high at 5 consecutive cycles, match_cnt=5.
- cfg_thresh=3, pattern 1001, send 8'b10010010 twice -> irq=1 the cycle after match_cnt reaches 3; stays 1 through match 4; irq_clr -> irq=0, match_cnt=0.
- CNT_W=2, run matches past 3 -> match_cnt stays 3; drop reset mid-SHIFT -> all outputs zero immediately, in_ready=1 after release.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the stream-fed serial pattern detector.
package seq_det_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Pattern loaded at reset; callers truncate it to their pattern width.
  localparam logic [31:0] DefaultPattern = 32'b1001;

endpackage

// File: rtl/seq_pat_det.sv
// Moore pattern detector: shifts one bit per enabled cycle and registers a one-cycle match flag.
module seq_pat_det #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             det
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             det_q;

  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], bit_in};
    fill_d = (fill_q == FillW'(PAT_W)) ? fill_q : fill_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else if (shift_en) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      // Only a fully primed history may report a match.
      det_q  <= (fill_d == FillW'(PAT_W)) && (hist_d == pattern);
    end else begin
      det_q  <= 1'b0;
    end
  end

  assign det = det_q;

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-bit sequencer feeding seq_pat_det, with match counting and a sticky threshold irq.
// Define SEQ_DET_LSB_FIRST_EN to serialize words LSB-first instead of MSB-first.
module seq_det_stream_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              irq_clr,
  output logic              ser_bit,
  output logic              busy,
  output logic              det,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq
);

  localparam int unsigned BitW = $clog2(WORD_W);

  state_e            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [BitW-1:0]   ser_idx;
  logic [PAT_W-1:0]  pattern_q;
  logic              run_q;
  logic              shifting, last_bit, accept, load_ok;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_chg_q, cnt_chg_d;
  logic              irq_q, irq_d;

  assign shifting = (state_q == StShift);
  assign last_bit = shifting && (bit_cnt_q == BitW'(WORD_W - 1));
  // run_q holds in_ready low until the first clock after reset release.
  assign in_ready = run_q && (!shifting || last_bit);
  assign accept   = in_valid && in_ready;
  assign load_ok  = cfg_load && !shifting;
  assign busy     = shifting;

`ifdef SEQ_DET_LSB_FIRST_EN
  assign ser_idx = bit_cnt_q;
`else
  assign ser_idx = BitW'(WORD_W - 1) - bit_cnt_q;
`endif

  assign ser_bit = shifting && shreg_q[ser_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      run_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q   <= in_data;
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (last_bit) begin
            bit_cnt_q <= '0;
            if (accept) shreg_q <= in_data;
            else        state_q <= StIdle;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pattern_q <= PAT_W'(DefaultPattern);
    else if (load_ok) pattern_q <= cfg_pattern;
  end

  seq_pat_det #(
    .PAT_W (PAT_W)
  ) u_det (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_ok),
    .shift_en (shifting),
    .bit_in   (ser_bit),
    .pattern  (pattern_q),
    .det      (det)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (irq_clr)                              cnt_d = CNT_W'(det);
    else if (det && cnt_q != {CNT_W{1'b1}})   cnt_d = cnt_q + 1'b1;
    // A clear coinciding with a match still counts as arriving at 1.
    cnt_chg_d = (cnt_d != cnt_q) || (irq_clr && det);
    irq_d = irq_clr ? 1'b0
                    : (irq_q || (cnt_chg_q && (cfg_thresh != '0) && (cnt_q == cfg_thresh)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      cnt_chg_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cnt_chg_q <= cnt_chg_d;
      irq_q     <= irq_d;
    end
  end

  assign match_cnt = cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Self-checking bench for seq_det_stream_ctrl: a queue-based stream model plus directed scenarios.
module tb_seq_det_stream_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_load;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              irq_clr;

  logic              in_ready, ser_bit, busy, det, irq;
  logic [CNT_W-1:0]  match_cnt;
  logic              in_ready2, ser_bit2, busy2, det2, irq2;
  logic [1:0]        match_cnt2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  seq_det_stream_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_thresh(cfg_thresh), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .irq_clr(irq_clr), .ser_bit(ser_bit), .busy(busy), .det(det), .match_cnt(match_cnt),
    .irq(irq)
  );

  // Narrow counter instance sharing all stimulus, for saturation behaviour.
  seq_det_stream_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_thresh(cfg_thresh[1:0]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .irq_clr(irq_clr), .ser_bit(ser_bit2), .busy(busy2), .det(det2),
    .match_cnt(match_cnt2), .irq(irq2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: pending bits of accepted words sit in a queue, the recent stream in another.
  bit         m_bitq[$];
  bit         m_hist[$];
  logic [3:0] m_pat = 4'b1001;
  logic       m_det = 1'b0, m_run = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic [1:0] m_cnt2 = 2'd0;
  logic       m_chg = 1'b0, m_chg2 = 1'b0, m_irq = 1'b0, m_irq2 = 1'b0;
  logic       e_ready = 1'b0, e_busy = 1'b0, e_ser = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bitq.delete();
      m_hist.delete();
      m_pat = 4'b1001; m_det = 0; m_run = 0;
      m_cnt = 0; m_chg = 0; m_irq = 0; m_cnt2 = 0; m_chg2 = 0; m_irq2 = 0;
    end else begin
      bit         cur_det, cur_ser, shifting, acc, tmp;
      logic [7:0] o8;
      logic [1:0] o2;
      cur_det  = m_det;
      shifting = (m_bitq.size() != 0);
      cur_ser  = shifting ? m_bitq[0] : 1'b0;
      acc      = in_valid && m_run && (m_bitq.size() <= 1);
      if (irq_clr) m_irq = 0;
      else if (m_chg && cfg_thresh != 0 && m_cnt == cfg_thresh) m_irq = 1;
      if (irq_clr) m_irq2 = 0;
      else if (m_chg2 && cfg_thresh[1:0] != 0 && m_cnt2 == cfg_thresh[1:0]) m_irq2 = 1;
      o8 = m_cnt;
      o2 = m_cnt2;
      if (irq_clr) begin
        m_cnt  = {7'd0, cur_det};
        m_cnt2 = {1'b0, cur_det};
      end else if (cur_det) begin
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
      m_chg  = (m_cnt != o8) || (irq_clr && cur_det);
      m_chg2 = (m_cnt2 != o2) || (irq_clr && cur_det);
      m_det = 0;
      if (cfg_load && !shifting) begin
        m_pat = cfg_pattern;
        m_hist.delete();
      end else if (shifting) begin
        m_hist.push_back(cur_ser);
        if (m_hist.size() > PAT_W) tmp = m_hist.pop_front();
        if (m_hist.size() == PAT_W) begin
          m_det = 1;
          for (int i = 0; i < PAT_W; i++) if (m_hist[i] != m_pat[PAT_W-1-i]) m_det = 0;
        end
        tmp = m_bitq.pop_front();
      end
      if (acc) begin
        for (int i = 0; i < WORD_W; i++) begin
`ifdef SEQ_DET_LSB_FIRST_EN
          m_bitq.push_back(in_data[i]);
`else
          m_bitq.push_back(in_data[WORD_W-1-i]);
`endif
        end
      end
      m_run = 1;
    end
    e_busy  = (m_bitq.size() != 0);
    e_ready = m_run && (m_bitq.size() <= 1);
    e_ser   = e_busy ? m_bitq[0] : 1'b0;
  end

  logic [19:0] act_v, exp_v;
  assign act_v = {det, in_ready, busy, ser_bit, irq, match_cnt,
                  det2, in_ready2, busy2, ser_bit2, irq2, match_cnt2};
  assign exp_v = {m_det, e_ready, e_busy, e_ser, m_irq, m_cnt,
                  m_det, e_ready, e_busy, e_ser, m_irq2, m_cnt2};

  task automatic test_reset();
    #12;
    n_chk++;
    if (act_v !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want all zero", act_v);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (act_v !== exp_v || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b (in_ready %b want 1)", act_v, exp_v, in_ready);
    end
  endtask

  task automatic test_detect();
    logic [7:0] words[$];
    int t_acc = -1, rdy_low = 0;
    int det_rel[$];
    words.push_back(8'b10010010);
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL detect cyc %0d: got %b want %b", cyc, act_v, exp_v);
      end
      if (t_acc >= 0 && det) det_rel.push_back(cyc - t_acc);
      if (t_acc >= 0 && cyc > t_acc && cyc <= t_acc + 7 && !in_ready) rdy_low++;
      if (words.size() != 0) begin
        in_valid = 1'b1;
        in_data  = words[0];
        if (e_ready) begin t_acc = cyc; words.pop_front(); end
      end else in_valid = 1'b0;
    end
    n_chk++;
    if (det_rel.size() != 2 || det_rel[0] != 5 || det_rel[1] != 8) begin
      n_fail++;
      $display("FAIL detect_timing: got %p want '{5, 8}", det_rel);
    end
    n_chk++;
    if (match_cnt !== 8'd2 || rdy_low != 7) begin
      n_fail++;
      $display("FAIL detect_count: match_cnt %0d want 2, ready-low cycles %0d want 7",
               match_cnt, rdy_low);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[$];
    int t1 = -1, t2 = -1, busy_hi = 0;
    int det_rel[$];
    words.push_back(8'b00000010);
    words.push_back(8'b01000000);
    for (int n = 0; n < 22; n++) begin
      @(negedge clk);
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", cyc, act_v, exp_v);
      end
      if (t1 >= 0 && det) det_rel.push_back(cyc - t1);
      if (t1 >= 0 && cyc > t1 && cyc <= t1 + 16 && busy) busy_hi++;
      if (words.size() != 0) begin
        in_valid = 1'b1;
        in_data  = words[0];
        if (e_ready) begin
          if (t1 < 0) t1 = cyc; else t2 = cyc;
          words.pop_front();
        end
      end else in_valid = 1'b0;
    end
    n_chk++;
    if (t2 - t1 != 8 || busy_hi != 16 || det_rel.size() != 1 || det_rel[0] != 11) begin
      n_fail++;
      $display("FAIL back_to_back_timing: accept gap %0d want 8, busy %0d want 16, det %p want '{11}",
               t2 - t1, busy_hi, det_rel);
    end
  endtask

  task automatic test_cfg_load();
    int t_acc = -1;
    int det_rel[$];
    cfg_pattern = 4'b1111;
    // Load pulsed mid-word must be ignored: 8'h99 still matches 1001 twice.
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL load_ignored cyc %0d: got %b want %b", cyc, act_v, exp_v);
      end
      if (t_acc >= 0 && det) det_rel.push_back(cyc - t_acc);
      cfg_load = (t_acc >= 0 && cyc == t_acc + 2);
      in_valid = (t_acc < 0);
      in_data  = 8'h99;
      if (t_acc < 0 && e_ready) t_acc = cyc;
    end
    n_chk++;
    if (det_rel.size() != 2 || det_rel[0] != 5 || det_rel[1] != 9) begin
      n_fail++;
      $display("FAIL load_ignored_timing: got %p want '{5, 9}", det_rel);
    end
    det_rel.delete();
    t_acc = -1;
    // Load, clear and word accept in one idle cycle: the word sees pattern 1111.
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL load_applied cyc %0d: got %b want %b", cyc, act_v, exp_v);
      end
      if (t_acc >= 0 && det) det_rel.push_back(cyc - t_acc);
      cfg_load = (n == 0);
      irq_clr  = (n == 0);
      in_valid = (n == 0);
      in_data  = 8'hFF;
      if (n == 0) t_acc = cyc;
    end
    n_chk++;
    if (det_rel.size() != 5 || det_rel[0] != 5 || det_rel[4] != 9 || match_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL load_applied_count: det %p want 5..9, match_cnt %0d want 5",
               det_rel, match_cnt);
    end
  endtask

  task automatic test_irq();
    logic [7:0] words[$];
    int tc3 = -1, ti = -1;
    words.push_back(8'b10010010);
    words.push_back(8'b10010010);
    cfg_thresh = 8'd3;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL irq cyc %0d: got %b want %b", cyc, act_v, exp_v);
      end
      if (tc3 < 0 && match_cnt == 8'd3) tc3 = cyc;
      if (ti < 0 && irq) ti = cyc;
      cfg_load    = (n == 0);
      cfg_pattern = 4'b1001;
      irq_clr     = (n == 0);
      if (n > 0 && words.size() != 0) begin
        in_valid = 1'b1;
        in_data  = words[0];
        if (e_ready) words.pop_front();
      end else in_valid = 1'b0;
    end
    n_chk++;
    if (tc3 < 0 || ti != tc3 + 1 || irq !== 1'b1 || match_cnt !== 8'd4 || match_cnt2 !== 2'd3) begin
      n_fail++;
      $display("FAIL irq_set: cnt3 at %0d irq at %0d (want +1), irq %b cnt %0d want 1/4, cnt2 %0d want 3",
               tc3, ti, irq, match_cnt, match_cnt2);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    n_chk++;
    if (irq !== 1'b0 || match_cnt !== 8'd0 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL irq_clear: irq %b cnt %0d want 0/0 (vec %b want %b)",
               irq, match_cnt, act_v, exp_v);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", cyc, act_v, exp_v);
      end
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = 8'($urandom);
      cfg_load    = ($urandom_range(0, 19) == 0);
      cfg_pattern = 4'($urandom);
      irq_clr     = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 63) == 0) cfg_thresh = 8'($urandom_range(0, 5));
    end
    in_valid = 1'b0; cfg_load = 1'b0; irq_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t_acc = -1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc %0d: got %b want %b", cyc, act_v, exp_v);
      end
      in_valid = (t_acc < 0);
      in_data  = 8'hA5;
      if (t_acc < 0 && e_ready) t_acc = cyc;
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (act_v !== 20'd0 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b want all zero", act_v);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_release: in_ready %b busy %b want 1/0 (vec %b want %b)",
               in_ready, busy, act_v, exp_v);
    end
  endtask

  initial begin
    cfg_load    = 1'b0;
    cfg_pattern = 4'b1001;
    cfg_thresh  = 8'd0;
    in_valid    = 1'b0;
    in_data     = '0;
    irq_clr     = 1'b0;
    test_reset();
    test_detect();
    test_back_to_back();
    test_cfg_load();
    test_irq();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
